// File: rtl/vga_line_fetch_if.sv
// Word-memory read port used by the VGA line fetcher: request/grant
// for addresses, in-order rvalid for returning data.
interface vga_line_fetch_if #(
  parameter int AW = 17
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [15:0]   mem_rdata;
  logic          mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/vga_line_fetch.sv
// Ping-pong line fetcher feeding the VGA timing generator with 2x horizontal doubling.
// Optional colour-bar test pattern input is enabled by defining VGA_LINE_FETCH_PATTERN_EN.
module vga_line_fetch #(
  parameter int BPP    = 4,
  parameter int AW     = 17,
  parameter int BASE   = 0,
  parameter int MAXOUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                newline,
  input  logic                advance,
  input  logic [7:0]          line,
`ifdef VGA_LINE_FETCH_PATTERN_EN
  input  logic                pattern,
`endif
  output logic [3*BPP-1:0]    pixel,
  vga_line_fetch_if.master    mem,
  output logic                underrun,
  input  logic                clr_underrun
);

  localparam int PW = 3 * BPP;
  localparam logic [8:0] NPIX = 9'd320;
  localparam logic [9:0] XMAX = 10'd639;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE, S_FLUSH} state_t;

  state_t        state, state_n;
  logic          front_sel;
  logic [3:0]    outstanding, out_n;
  logic [8:0]    issued, issued_inc, issued_n;
  logic [8:0]    wr_cnt, wr_inc, wr_n;
  logic [7:0]    t_q, t_new, start_t;
  logic [AW-1:0] addr_n;
  logic          grant, rv_dec, wr_en, start, set_ur, req_n;
  logic [9:0]    x, x_inc;
  logic [8:0]    rd_idx;
  logic          rd_en, pix_valid;
  logic [PW-1:0] wdata, q0, q1, ram_pix;
  logic [PW-1:0] ram0 [320];
  logic [PW-1:0] ram1 [320];
  logic          unused_rdata;

  function automatic logic [AW-1:0] line_base(input logic [7:0] t);
    logic [AW-1:0] tw;
    tw = AW'(t);
    return AW'(BASE) + (tw << 8) + (tw << 6);
  endfunction

  assign grant        = mem.mem_req & mem.mem_gnt;
  assign rv_dec       = mem.mem_rvalid & (outstanding != 4'd0);
  assign wr_en        = mem.mem_rvalid & ((state == S_FETCH) | (state == S_DRAIN)) & (wr_cnt != NPIX);
  assign wdata        = mem.mem_rdata[PW-1:0];
  assign unused_rdata = ^mem.mem_rdata[15:PW];
  assign t_new        = (line < 8'd239) ? line + 8'd1 : 8'd0;
  assign out_n        = outstanding + {3'b000, grant} - {3'b000, rv_dec};
  assign issued_inc   = issued + {8'd0, grant};
  assign wr_inc       = wr_cnt + {8'd0, wr_en};

  // A newline in FETCH/DRAIN counts as complete only if this cycle's write is the 320th.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    set_ur  = 1'b0;
    start_t = t_q;
    if (newline) begin
      start_t = t_new;
      case (state)
        S_FETCH, S_DRAIN: begin
          if (wr_inc != NPIX) begin
            set_ur = 1'b1;
            if (out_n != 4'd0) state_n = S_FLUSH;
            else               start   = 1'b1;
          end else begin
            start = 1'b1;
          end
        end
        S_FLUSH: begin
          set_ur = 1'b1;
          if (out_n == 4'd0) start = 1'b1;
        end
        default: start = 1'b1;
      endcase
    end else begin
      case (state)
        S_FETCH: if (issued_inc == NPIX) state_n = S_DRAIN;
        S_DRAIN: if (wr_inc == NPIX) state_n = S_DONE;
        S_FLUSH: if (out_n == 4'd0) start = 1'b1;
        default: ;
      endcase
    end
    if (start) state_n = S_FETCH;
    issued_n = start ? 9'd0 : issued_inc;
    wr_n     = start ? 9'd0 : wr_inc;
    addr_n   = start ? line_base(start_t) : mem.mem_addr + AW'(grant);
    req_n    = (state_n == S_FETCH) && (issued_n != NPIX) && (out_n < 4'(MAXOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      front_sel    <= 1'b0;
      outstanding  <= 4'd0;
      issued       <= 9'd0;
      wr_cnt       <= 9'd0;
      t_q          <= 8'd0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      underrun     <= 1'b0;
      x            <= 10'd0;
      pix_valid    <= 1'b0;
    end else begin
      state        <= state_n;
      outstanding  <= out_n;
      issued       <= issued_n;
      wr_cnt       <= wr_n;
      mem.mem_req  <= req_n;
      mem.mem_addr <= addr_n;
      if (newline) begin
        front_sel <= ~front_sel;
        t_q       <= t_new;
        x         <= 10'd0;
        pix_valid <= 1'b1;
      end else if (advance) begin
        x <= x_inc;
      end
      if (set_ur)            underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

  // Read one index ahead: on newline fetch entry 0 of the buffer that becomes front.
  assign x_inc  = (x == XMAX) ? XMAX : x + 10'd1;
  assign rd_idx = newline ? 9'd0 : x_inc[9:1];
  assign rd_en  = newline | advance;

  always_ff @(posedge clk) begin
    if (wr_en && front_sel) ram0[wr_cnt] <= wdata;
    if (rd_en) q0 <= ram0[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !front_sel) ram1[wr_cnt] <= wdata;
    if (rd_en) q1 <= ram1[rd_idx];
  end

  assign ram_pix = front_sel ? q1 : q0;

`ifdef VGA_LINE_FETCH_PATTERN_EN
  logic       pat_q;
  logic [2:0] bar_q;

  function automatic logic [2:0] bar_of(input logic [8:0] idx);
    logic [2:0] b;
    b = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (idx < 9'((i + 1) * 40)) b = 3'(i);
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 1'b0;
      bar_q <= 3'd0;
    end else begin
      pat_q <= pattern;
      if (rd_en) bar_q <= bar_of(rd_idx);
    end
  end

  assign pixel = !pix_valid ? '0 :
                 pat_q ? {{BPP{bar_q[2]}}, {BPP{bar_q[1]}}, {BPP{bar_q[0]}}} : ram_pix;
`else
  assign pixel = pix_valid ? ram_pix : '0;
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: in-order memory model with configurable
// grant rate and latency, 800-cycle lines with 640 advance cycles.
module tb_vga_line_fetch;

  localparam int BPP = 4;
  localparam int AW  = 17;
  localparam int PW  = 3 * BPP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          newline = 1'b0;
  logic          advance = 1'b0;
  logic          clr_underrun = 1'b0;
  logic [7:0]    line = 8'd0;
  logic [PW-1:0] pixel;
  logic          underrun;
`ifdef VGA_LINE_FETCH_PATTERN_EN
  logic          pattern = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_line_fetch_if #(.AW(AW)) mem_if ();

  vga_line_fetch #(.BPP(BPP), .AW(AW), .BASE(0), .MAXOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .newline      (newline),
    .advance      (advance),
    .line         (line),
`ifdef VGA_LINE_FETCH_PATTERN_EN
    .pattern      (pattern),
`endif
    .pixel        (pixel),
    .mem          (mem_if),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct 12-bit value per address with junk in the upper nibble.
  function automatic logic [15:0] md(input int a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    return {4'hA, aa[11:0] ^ 12'h5A3};
  endfunction

  function automatic logic [PW-1:0] mpix(input int a);
    logic [15:0] w;
    w = md(a);
    return w[PW-1:0];
  endfunction

  int            cyc = 0;
  int            gnt_period = 1;
  int            latency = 2;
  logic [AW-1:0] pq_addr[$];
  int            pq_due[$];
  logic [AW-1:0] glog[$];
  logic [PW-1:0] cap[640];

  always @(negedge clk) begin
    cyc = cyc + 1;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 16'h0000;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = md(int'(pq_addr[0]));
      void'(pq_due.pop_front());
      void'(pq_addr.pop_front());
    end
    if (mem_if.mem_req && (cyc % gnt_period == 0)) begin
      mem_if.mem_gnt = 1'b1;
      pq_addr.push_back(mem_if.mem_addr);
      pq_due.push_back(cyc + latency);
      glog.push_back(mem_if.mem_addr);
    end else begin
      mem_if.mem_gnt = 1'b0;
    end
  end

  function automatic int seq_errors(input int base);
    int e;
    e = 0;
    for (int i = 0; i < glog.size(); i++) begin
      if (glog[i] !== AW'(base + i)) e++;
    end
    return e;
  endfunction

  function automatic int glog_at(input int i);
    if (i < glog.size()) return int'(glog[i]);
    return -1;
  endfunction

  task automatic pulse_newline(input logic [7:0] ln);
    @(negedge clk);
    newline = 1'b1;
    line    = ln;
    advance = 1'b0;
    @(negedge clk);
    newline = 1'b0;
  endtask

  // One 800-cycle line: newline at cycle 0, advance on cycles 16..655.
  task automatic run_line(input logic [7:0] ln, input bit capture);
    @(negedge clk);
    newline = 1'b1;
    line    = ln;
    advance = 1'b0;
    for (int c = 1; c < 800; c++) begin
      @(negedge clk);
      newline = 1'b0;
      if (capture && c >= 16 && c < 656) cap[c-16] = pixel;
      advance = (c >= 16 && c < 656);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req: got %b want 0", mem_if.mem_req); end
    n_cmp++; if (mem_if.mem_addr !== '0) begin n_bad++; $display("[TB] FAIL reset_addr: got %0d want 0", mem_if.mem_addr); end
    n_cmp++; if (pixel !== '0) begin n_bad++; $display("[TB] FAIL reset_pixel: got %h want 0", pixel); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_scan;
    gnt_period = 1;
    latency    = 2;
    glog.delete();
    run_line(8'd5, 1'b0);
    n_cmp++; if (glog.size() !== 320) begin n_bad++; $display("[TB] FAIL fetch5_count: got %0d want 320", glog.size()); end
    n_cmp++; if (glog_at(0) !== 1920) begin n_bad++; $display("[TB] FAIL fetch5_first: got %0d want 1920", glog_at(0)); end
    n_cmp++; if (glog_at(319) !== 2239) begin n_bad++; $display("[TB] FAIL fetch5_last: got %0d want 2239", glog_at(319)); end
    n_cmp++; if (seq_errors(1920) !== 0) begin n_bad++; $display("[TB] FAIL fetch5_seq: got %0d bad addrs want 0", seq_errors(1920)); end
    glog.delete();
    run_line(8'd6, 1'b1);
    n_cmp++; if (cap[0] !== mpix(1920)) begin n_bad++; $display("[TB] FAIL scan_k0: got %h want %h", cap[0], mpix(1920)); end
    n_cmp++; if (cap[1] !== mpix(1920)) begin n_bad++; $display("[TB] FAIL scan_k1: got %h want %h", cap[1], mpix(1920)); end
    n_cmp++; if (cap[2] !== mpix(1921)) begin n_bad++; $display("[TB] FAIL scan_k2: got %h want %h", cap[2], mpix(1921)); end
    n_cmp++; if (cap[638] !== mpix(2239)) begin n_bad++; $display("[TB] FAIL scan_k638: got %h want %h", cap[638], mpix(2239)); end
    n_cmp++; if (cap[639] !== mpix(2239)) begin n_bad++; $display("[TB] FAIL scan_k639: got %h want %h", cap[639], mpix(2239)); end
    begin
      int e;
      e = 0;
      for (int k = 0; k < 640; k++) if (cap[k] !== mpix(1920 + k / 2)) e++;
      n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL scan_all: got %0d bad pixels want 0", e); end
    end
    n_cmp++; if (pixel !== mpix(2239)) begin n_bad++; $display("[TB] FAIL scan_hold: got %h want %h", pixel, mpix(2239)); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("[TB] FAIL scan_underrun: got %b want 0", underrun); end
    n_cmp++; if (glog_at(0) !== 2240) begin n_bad++; $display("[TB] FAIL fetch6_first: got %0d want 2240", glog_at(0)); end
  endtask

  task automatic test_wrap;
    glog.delete();
    run_line(8'd239, 1'b0);
    n_cmp++; if (glog.size() !== 320) begin n_bad++; $display("[TB] FAIL wrap239_count: got %0d want 320", glog.size()); end
    n_cmp++; if (glog_at(0) !== 0) begin n_bad++; $display("[TB] FAIL wrap239_first: got %0d want 0", glog_at(0)); end
    n_cmp++; if (seq_errors(0) !== 0) begin n_bad++; $display("[TB] FAIL wrap239_seq: got %0d bad addrs want 0", seq_errors(0)); end
    glog.delete();
    run_line(8'd255, 1'b0);
    n_cmp++; if (glog.size() !== 320) begin n_bad++; $display("[TB] FAIL wrap255_count: got %0d want 320", glog.size()); end
    n_cmp++; if (glog_at(319) !== 319) begin n_bad++; $display("[TB] FAIL wrap255_last: got %0d want 319", glog_at(319)); end
    n_cmp++; if (seq_errors(0) !== 0) begin n_bad++; $display("[TB] FAIL wrap255_seq: got %0d bad addrs want 0", seq_errors(0)); end
  endtask

  task automatic test_underrun;
    bit found;
    gnt_period = 3;
    latency    = 4;
    run_line(8'd10, 1'b0);
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("[TB] FAIL ur_before: got %b want 0", underrun); end
    pulse_newline(8'd11);
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("[TB] FAIL ur_set: got %b want 1", underrun); end
    n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL ur_flush_req: got %b want 0", mem_if.mem_req); end
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (mem_if.mem_req) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL ur_refetch_timeout: got no request want request within 200 cycles"); end
    n_cmp++; if (pq_due.size() !== 0) begin n_bad++; $display("[TB] FAIL ur_drained: got %0d pending want 0", pq_due.size()); end
    n_cmp++; if (mem_if.mem_addr !== AW'(3840)) begin n_bad++; $display("[TB] FAIL ur_refetch_addr: got %0d want 3840", mem_if.mem_addr); end
    glog.delete();
    gnt_period = 1;
    latency    = 2;
    @(negedge clk);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("[TB] FAIL ur_clear: got %b want 0", underrun); end
    repeat (600) @(negedge clk);
    n_cmp++; if (glog.size() !== 320) begin n_bad++; $display("[TB] FAIL ur_refetch_count: got %0d want 320", glog.size()); end
    n_cmp++; if (seq_errors(3840) !== 0) begin n_bad++; $display("[TB] FAIL ur_refetch_seq: got %0d bad addrs want 0", seq_errors(3840)); end
  endtask

  task automatic test_outstanding;
    latency = 20;
    glog.delete();
    pulse_newline(8'd0);
    repeat (14) @(negedge clk);
    n_cmp++; if (glog.size() !== 4) begin n_bad++; $display("[TB] FAIL maxout_grants: got %0d want 4", glog.size()); end
    n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL maxout_req: got %b want 0", mem_if.mem_req); end
    n_cmp++; if (glog_at(0) !== 320) begin n_bad++; $display("[TB] FAIL maxout_first: got %0d want 320", glog_at(0)); end
    repeat (15) @(negedge clk);
    n_cmp++; if ((glog.size() > 4) !== 1'b1) begin n_bad++; $display("[TB] FAIL maxout_resume: got %0d grants want more than 4", glog.size()); end
  endtask

  task automatic test_reset_midfetch;
    bit found;
    n_cmp++; if (pixel !== mpix(3840)) begin n_bad++; $display("[TB] FAIL pre_reset_pixel: got %h want %h", pixel, mpix(3840)); end
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_if.mem_req) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL midfetch_req_timeout: got no request want request within 50 cycles"); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL async_req: got %b want 0", mem_if.mem_req); end
    n_cmp++; if (pixel !== '0) begin n_bad++; $display("[TB] FAIL async_pixel: got %h want 0", pixel); end
    n_cmp++; if (mem_if.mem_addr !== '0) begin n_bad++; $display("[TB] FAIL async_addr: got %0d want 0", mem_if.mem_addr); end
    pq_addr.delete();
    pq_due.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    latency = 2;
    glog.delete();
    run_line(8'd0, 1'b0);
    n_cmp++; if (glog.size() !== 320) begin n_bad++; $display("[TB] FAIL restart_count: got %0d want 320", glog.size()); end
    n_cmp++; if (glog_at(0) !== 320) begin n_bad++; $display("[TB] FAIL restart_first: got %0d want 320", glog_at(0)); end
    n_cmp++; if (seq_errors(320) !== 0) begin n_bad++; $display("[TB] FAIL restart_seq: got %0d bad addrs want 0", seq_errors(320)); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("[TB] FAIL restart_underrun: got %b want 0", underrun); end
  endtask

`ifdef VGA_LINE_FETCH_PATTERN_EN
  task automatic test_pattern;
    pattern = 1'b1;
    run_line(8'd20, 1'b1);
    n_cmp++; if (cap[0] !== 12'h000) begin n_bad++; $display("[TB] FAIL bar_k0: got %h want 000", cap[0]); end
    n_cmp++; if (cap[80] !== 12'h00F) begin n_bad++; $display("[TB] FAIL bar_k80: got %h want 00f", cap[80]); end
    n_cmp++; if (cap[240] !== 12'h0FF) begin n_bad++; $display("[TB] FAIL bar_k240: got %h want 0ff", cap[240]); end
    n_cmp++; if (cap[560] !== 12'hFFF) begin n_bad++; $display("[TB] FAIL bar_k560: got %h want fff", cap[560]); end
    pattern = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_scan();
    test_wrap();
    test_underrun();
    test_outstanding();
    test_reset_midfetch();
`ifdef VGA_LINE_FETCH_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Upstream feeder for the VGA timing generator. Supplies one 3*BPP-bit pixel per advance cycle from a 320x240 framebuffer in external word memory.
- Uses a ping-pong pair of 320-entry line buffers. While the front buffer is scanned out with 2x horizontal doubling, the back buffer is filled from memory for the next source line.
- Consumes the generator's newline/advance/line signals and drives its pixel input.

Parameters:
- BPP, 4, bits per colour channel; pixel width is 3*BPP.
- AW, 17, memory word-address width.
- BASE, 0, word address of framebuffer pixel (0,0).
- MAXOUT, 4, maximum outstanding memory reads (1..15).

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst_n  in  1  asynchronous active-low reset
- newline  in  1  one-cycle pulse at line start, from the timing generator
- advance  in  1  high on each active display pixel cycle
- line  in  8  current source line index (0..239; 255 during pre-display blanking)
- pixel  out  3*BPP  pixel for the current advance cycle
- mem_req  out  1  read request, held until granted
- mem_addr  out  AW  read word address, stable while mem_req is high
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  16  read data; bits [3*BPP-1:0] hold the pixel
- mem_rvalid  in  1  read data valid; returns in request order, any latency >= 1
- underrun  out  1  sticky flag: a fetch failed to complete before newline
- clr_underrun  in  1  synchronous clear of underrun

Behaviour:
- Reset (rst_n low, asynchronous):
  - mem_req=0, mem_addr=0, pixel=0, underrun=0.
  - FSM=IDLE, front select=0, outstanding=0.
  - Line buffer contents are not reset.
- Target line on newline: T = (line < 239) ? line+1 : 0. For example, line=255 gives T=0 and line=239 gives T=0.
- Line base address: BASE + T*320, computed by shift-add. The address wraps modulo 2^AW.
- newline actions, all in the same cycle:
  - swap front and back buffers;
  - reset scan counter x to 0;
  - latch T;
  - start a fetch.
- FSM states:
  - IDLE: waits for newline, then goes to FETCH.
  - FETCH: issues addresses base+0..base+319.
    - mem_req is asserted when outstanding < MAXOUT.
    - Address increments on each mem_gnt; outstanding increments on grant without rvalid.
    - After the 320th grant, goes to DRAIN.
  - DRAIN: waits for all returns. When 320 words have been written, goes to DONE.
  - DONE: waits for newline, then goes to FETCH.
  - FLUSH: mem_req=0. rvalids are discarded and decrement outstanding. When outstanding reaches 0, goes to FETCH for the latched T.
- Write path: the k-th rvalid of a fetch writes mem_rdata[3*BPP-1:0] to back[k], k=0..319.
- Simultaneous events:
  - rvalid and grant in the same cycle leave outstanding unchanged.
  - newline and a final rvalid in the same cycle: the rvalid is written to the old back buffer first, then the swap happens. This counts as complete, with no underrun.
- Underrun: newline arriving while FSM is in FETCH or DRAIN (320 writes not yet done):
  - sets underrun;
  - swaps anyway;
  - goes to FLUSH if outstanding > 0, otherwise to FETCH.
  - newline arriving in FLUSH also sets underrun and re-latches T.
  - clr_underrun clears the flag unless a new underrun occurs in the same cycle; set wins.
- Scan-out:
  - During the k-th advance cycle after newline (k=0..639), pixel = front[k>>1].
  - pixel is registered. The buffer read address is pre-advanced so that index 0 is presented by the cycle after newline and holds until the first advance.
  - After k=639, x saturates and pixel holds front[319].
  - With advance low, pixel holds its value.
- Line buffers: two 320 x 3*BPP simple dual-port RAMs, inferable as block RAM.

Optional Feature:
- Macro: VGA_LINE_FETCH_PATTERN_EN.
- When defined:
  - Adds input pattern (1 bit).
  - While pattern=1, pixel = colour bar for (k>>1)/40, i.e. 8 bars of 40 source pixels each.
  - Bar colours: bit2 to R, bit1 to G, bit0 to B, each channel all-ones or zero. Bar 0 is black, bar 7 is white.
  - Memory fetches continue unchanged.
- When undefined: no pattern port, and pixel always comes from the front buffer.

Test Plan:
- Memory model with 2-cycle latency, always granting; line=5 newline -> 320 requests at addresses 1920..2239 (BASE=0). At the next newline, advance cycles 0..639 give pixel sequence mem[1920],mem[1920],mem[1921],... ending at mem[2239] twice; underrun=0.
- line=239 newline -> fetch addresses 0..319. line=255 newline -> also addresses 0..319.
- Grant only every 3rd cycle with latency 4 -> fetch not finished at the 800-cycle newline, so underrun=1 and FSM goes to FLUSH. Outstanding drains to 0 before the new fetch's first request. clr_underrun pulse -> underrun=0.
- Outstanding limit: mem_gnt=1 with rvalid delayed 20 cycles -> exactly MAXOUT=4 grants, then mem_req=0 until rvalids return.
- Assert rst_n low mid-FETCH -> mem_req=0 and pixel=0 immediately, without waiting for a clock edge. After release plus newline line=0, the fetch restarts at address 320.
- With VGA_LINE_FETCH_PATTERN_EN and pattern=1 (BPP=4): k=0 gives 0x000, k=80 gives 0x00F, k=560 gives 0xFFF.
